// File: rtl/v2f_seq_pkg.sv
// ---------------------------------------------------------------------------
// v2f_seq_pkg
// Shared definitions for the sequential exponentiation unit and for the
// simulator model on the techmap side.
//   state_e        : FSM states (IDLE, RUN, FIN)
//   WIDTH_MAX      : widest operand the unit supports
//   neg_exp_result : result of A ** B when B is a negative exponent
// ---------------------------------------------------------------------------
package v2f_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int WIDTH_MAX = 32;

  // Negative exponent: only |a| == 1 gives a non-zero integer result.
  // 'a' is zero-extended from 'width' bits. The result is returned in
  // WIDTH_MAX bits; callers keep the low 'width' bits.
  function automatic logic [WIDTH_MAX-1:0] neg_exp_result(
    input logic [WIDTH_MAX-1:0] a,
    input logic                 b_odd,
    input logic                 a_signed,
    input int                   width
  );
    logic [WIDTH_MAX-1:0] mask;
    logic [WIDTH_MAX-1:0] a_m;
    logic [WIDTH_MAX-1:0] res;
    mask = {WIDTH_MAX{1'b1}} >> (WIDTH_MAX - width);
    a_m  = a & mask;
    res  = '0;
    if (a_m == WIDTH_MAX'(1)) begin
      res = WIDTH_MAX'(1);
    end else if (a_signed && (a_m == mask)) begin
      // (-1) ** b is -1 for odd b, +1 for even b
      res = b_odd ? mask : WIDTH_MAX'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/v2f_pow_step.sv
// ---------------------------------------------------------------------------
// v2f_pow_step
// One square-and-multiply iteration, purely combinational.
//   acc, base  : current accumulator and running square
//   exp_lsb    : current exponent bit; when set the base is folded into acc
//   next_acc   : acc * base if exp_lsb, else acc   (mod 2^WIDTH)
//   next_base  : base * base                       (mod 2^WIDTH)
// ---------------------------------------------------------------------------
module v2f_pow_step
  import v2f_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] base,
  input  logic             exp_lsb,
  output logic [WIDTH-1:0] next_acc,
  output logic [WIDTH-1:0] next_base
);

  // Operands and results are all WIDTH bits wide, so the products are
  // truncated modulo 2^WIDTH; signed and unsigned bit patterns coincide.
  logic [WIDTH-1:0] prod_acc;

  assign prod_acc  = acc * base;
  assign next_base = base * base;
  assign next_acc  = exp_lsb ? prod_acc : acc;

endmodule

// File: rtl/v2f_pow_seq.sv
// ---------------------------------------------------------------------------
// v2f_pow_seq
// Multi-cycle Y = A ** B (Verilog $pow semantics, truncated to WIDTH bits)
// using square-and-multiply, one exponent bit per clock.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, only sampled while idle
//   a, b   : base and exponent, captured when start is accepted
//   busy   : high while an operation is in flight (including the done cycle)
//   done   : one-cycle pulse, y is valid in that cycle
//   y      : result, held until the next done
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module v2f_pow_seq
  import v2f_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] y_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] base_d;
  logic [WIDTH-1:0] exp_d;
  logic             b_neg;
  logic [WIDTH_MAX-1:0] neg_y_wide;
  logic [WIDTH-1:0] neg_y;

  v2f_pow_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_q),
    .base      (base_q),
    .exp_lsb   (exp_q[0]),
    .next_acc  (acc_d),
    .next_base (base_d)
  );

  assign exp_d = exp_q >> 1;
  assign b_neg = (B_SIGNED != 0) && b[WIDTH-1];

  assign neg_y_wide = neg_exp_result(WIDTH_MAX'(a), b[0], (A_SIGNED != 0), WIDTH);
  assign neg_y      = neg_y_wide[WIDTH-1:0];

  // done and y are loaded on the transition into FIN so that they are
  // registered yet already valid during the FIN cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= a;
            exp_q  <= b;
            acc_q  <= WIDTH'(1);
            busy_q <= 1'b1;
            if (b_neg) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              y_q     <= neg_y;
            end else if (b == '0) begin
              // x ** 0 == 1, including 0 ** 0
              state_q <= FIN;
              done_q  <= 1'b1;
              y_q     <= WIDTH'(1);
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          base_q <= base_d;
          exp_q  <= exp_d;
          if (exp_d == '0) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            y_q     <= acc_d;
          end
        end
        FIN: begin
          // start is ignored here; the next request is taken in IDLE
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule
